// File: rtl/mii_tx_serializer.sv
// MII transmit serializer: streams 32-bit frame words out as nibbles with preamble/SFD,
// zero pad to the minimum frame size, CRC-32 FCS and an inter-packet gap.
module mii_tx_serializer #(
  parameter int unsigned IFG_NIBBLES     = 24,
  parameter int unsigned MIN_FRAME_BYTES = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_tdata,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic        s_tlast,
  input  logic [3:0]  s_tkeep,
  output logic [3:0]  phy_txd,
  output logic        phy_tx_en,
  output logic        phy_tx_er,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frames_sent
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] PREAMBLE = 3'd1;
  localparam logic [2:0] DATA     = 3'd2;
  localparam logic [2:0] PAD      = 3'd3;
  localparam logic [2:0] FCS      = 3'd4;
  localparam logic [2:0] IFG      = 3'd5;

  localparam logic [15:0] IFG_LAST  = 16'(IFG_NIBBLES - 1);
  localparam logic [10:0] MIN_BYTES = 11'(MIN_FRAME_BYTES);

  logic [2:0]  state;
  logic [3:0]  cnt;
  logic [2:0]  widx;
  logic [31:0] word;
  logic        word_last;
  logic [2:0]  word_end;
  logic [10:0] byte_cnt;
  logic [31:0] crc;
  logic [15:0] ifg_cnt;

  logic [31:0] crc_next;
  logic [31:0] crc_inv;
  logic [10:0] byte_next;
  logic [2:0]  widx_inc;
  logic [2:0]  fcs_idx;

  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c ^ {28'd0, d};
    for (int unsigned i = 0; i < 4; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [2:0] last_nibble(input logic [3:0] keep);
    case (keep)
      4'b0001: return 3'd1;
      4'b0011: return 3'd3;
      4'b0111: return 3'd5;
      default: return 3'd7;
    endcase
  endfunction

  always_comb begin
    crc_next  = crc_nibble(crc, phy_txd);
    crc_inv   = ~crc;
    byte_next = (widx[0] && byte_cnt != 11'h7FF) ? byte_cnt + 11'd1 : byte_cnt;
    widx_inc  = widx + 3'd1;
    fcs_idx   = cnt[2:0] + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      widx        <= '0;
      word        <= '0;
      word_last   <= 1'b0;
      word_end    <= '0;
      byte_cnt    <= '0;
      crc         <= '1;
      ifg_cnt     <= '0;
      s_tready    <= 1'b0;
      phy_txd     <= '0;
      phy_tx_en   <= 1'b0;
      phy_tx_er   <= 1'b0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
      frames_sent <= '0;
    end else begin
      underrun <= 1'b0;
      // s_tready is only ever high on the final nibble of the SFD or of a non-last word,
      // so the handshake (or underrun) is resolved here for both states.
      if (s_tready) begin
        s_tready <= 1'b0;
        if (state == DATA) begin
          crc      <= crc_next;
          byte_cnt <= byte_next;
        end
        if (s_tvalid) begin
          state     <= DATA;
          word      <= s_tdata;
          word_last <= s_tlast;
          word_end  <= s_tlast ? last_nibble(s_tkeep) : 3'd7;
          widx      <= '0;
          phy_txd   <= s_tdata[3:0];
        end else begin
          state     <= IFG;
          ifg_cnt   <= '0;
          phy_txd   <= '0;
          phy_tx_er <= 1'b1;
          underrun  <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (s_tvalid) begin
              state     <= PREAMBLE;
              busy      <= 1'b1;
              phy_tx_en <= 1'b1;
              phy_txd   <= 4'h5;
              cnt       <= '0;
              crc       <= '1;
              byte_cnt  <= '0;
            end
          end
          PREAMBLE: begin
            cnt <= cnt + 4'd1;
            if (cnt == 4'd14) begin
              phy_txd  <= 4'hD;
              s_tready <= 1'b1;
            end
          end
          DATA: begin
            crc      <= crc_next;
            byte_cnt <= byte_next;
            if (widx != word_end) begin
              widx    <= widx_inc;
              phy_txd <= word[{widx_inc, 2'b00} +: 4];
              if (!word_last && widx_inc == 3'd7) s_tready <= 1'b1;
            end else if (byte_next < MIN_BYTES) begin
              state   <= PAD;
              widx    <= '0;
              phy_txd <= '0;
            end else begin
              state   <= FCS;
              cnt     <= '0;
              phy_txd <= ~crc_next[3:0];
            end
          end
          PAD: begin
            crc      <= crc_next;
            byte_cnt <= byte_next;
            widx     <= {2'b00, ~widx[0]};
            if (widx[0] && byte_next >= MIN_BYTES) begin
              state   <= FCS;
              cnt     <= '0;
              phy_txd <= ~crc_next[3:0];
            end else begin
              phy_txd <= '0;
            end
          end
          FCS: begin
            if (cnt[2:0] == 3'd7) begin
              state       <= IFG;
              ifg_cnt     <= '0;
              phy_tx_en   <= 1'b0;
              phy_txd     <= '0;
              frames_sent <= frames_sent + 16'd1;
            end else begin
              cnt     <= cnt + 4'd1;
              phy_txd <= crc_inv[{fcs_idx, 2'b00} +: 4];
            end
          end
          IFG: begin
            phy_tx_en <= 1'b0;
            phy_tx_er <= 1'b0;
            phy_txd   <= '0;
            // the aborted-frame error nibble is not part of the gap
            if (!phy_tx_er) begin
              if (ifg_cnt == IFG_LAST) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                ifg_cnt <= ifg_cnt + 16'd1;
              end
            end
          end
          default: begin
            state     <= IDLE;
            busy      <= 1'b0;
            phy_tx_en <= 1'b0;
            phy_tx_er <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
